// File: rtl/mimo_rx_pkg.sv
// Shared constants and elaboration helpers for the MIMO receive combiner.
package mimo_rx_pkg;

  // Combine mode encodings carried alongside each sample.
  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Width of an exact N-way sum of in_w-bit signed words.
  function automatic int unsigned full_width(input int unsigned in_w, input int unsigned n_ch);
    return in_w + clog2(n_ch);
  endfunction

endpackage

// File: rtl/mimo_add_stage.sv
// One registered pairwise adder level of the combiner tree.
// Reduces IN_CNT signed W-bit words to IN_CNT/2 signed (W+1)-bit words for both I and Q,
// and carries the sample's valid and mode bits alongside.
module mimo_add_stage #(
  parameter int unsigned IN_CNT = 4,
  parameter int unsigned W      = 6
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             valid_i,
  input  logic                             mode_i,
  input  logic [IN_CNT*W-1:0]              i_i,
  input  logic [IN_CNT*W-1:0]              q_i,
  output logic                             valid_o,
  output logic                             mode_o,
  output logic [(IN_CNT/2)*(W+1)-1:0]      i_o,
  output logic [(IN_CNT/2)*(W+1)-1:0]      q_o
);

  localparam int unsigned OutCnt = IN_CNT / 2;
  localparam int unsigned OW     = W + 1;

  logic                    valid_q;
  logic                    mode_d, mode_q;
  logic [OutCnt*OW-1:0]    i_d, i_q;
  logic [OutCnt*OW-1:0]    q_d, q_q;

  // Words 2j and 2j+1 are sign-extended by one bit and summed into output word j.
  // Data and mode only load on a valid sample so bubbles leave the level untouched.
  always_comb begin
    i_d    = i_q;
    q_d    = q_q;
    mode_d = mode_q;
    if (valid_i) begin
      mode_d = mode_i;
      for (int unsigned j = 0; j < OutCnt; j++) begin
        i_d[j*OW +: OW] = OW'($signed(i_i[(2*j)*W +: W])) + OW'($signed(i_i[(2*j+1)*W +: W]));
        q_d[j*OW +: OW] = OW'($signed(q_i[(2*j)*W +: W])) + OW'($signed(q_i[(2*j+1)*W +: W]));
      end
    end
  end

  // Level registers; valid follows the input every cycle so bubbles pass through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      valid_q <= valid_i;
      mode_q  <= mode_d;
      i_q     <= i_d;
      q_q     <= q_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign i_o     = i_q;
  assign q_o     = q_q;

endmodule

// File: rtl/mimo_rx_combiner.sv
// N-chain receive I/Q combiner: masked input register, registered log2(N) adder tree,
// optional rounded average, saturation to OUT_W and a sticky clip flag.
// Fixed latency of log2(N_CH)+2 cycles, one sample per clock, no backpressure.
module mimo_rx_combiner
  import mimo_rx_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IN_W  = 6,
  parameter int unsigned OUT_W = IN_W + clog2(N_CH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  input  logic [N_CH*IN_W-1:0]   I_IN,
  input  logic [N_CH*IN_W-1:0]   Q_IN,
  input  logic [N_CH-1:0]        CH_EN,
  input  logic                   MODE,
  input  logic                   CLR_FLAG,
  output logic                   OUT_VALID,
  output logic [OUT_W-1:0]       I_TOTAL,
  output logic [OUT_W-1:0]       Q_TOTAL,
  output logic                   SAT_FLAG
);

  localparam int unsigned Lvls  = clog2(N_CH);
  localparam int unsigned FW    = full_width(IN_W, N_CH);
  // One spare bit keeps the rounding add exact before the shift.
  localparam int unsigned RW    = FW + 1;
  localparam bit          SatEn = (OUT_W < FW);

  localparam logic signed [RW-1:0] Half = RW'(1 << (Lvls - 1));

  // ---------------------------------------------------------------------------
  // Stage 0: input register with chain masking
  // ---------------------------------------------------------------------------
  logic                   valid_s0_q;
  logic                   mode_s0_d, mode_s0_q;
  logic [N_CH*IN_W-1:0]   i_s0_d, i_s0_q;
  logic [N_CH*IN_W-1:0]   q_s0_d, q_s0_q;

  // Disabled chains are zeroed here so the tree never sees them.
  always_comb begin
    i_s0_d    = i_s0_q;
    q_s0_d    = q_s0_q;
    mode_s0_d = mode_s0_q;
    if (IN_VALID) begin
      mode_s0_d = MODE;
      for (int unsigned k = 0; k < N_CH; k++) begin
        i_s0_d[k*IN_W +: IN_W] = CH_EN[k] ? I_IN[k*IN_W +: IN_W] : '0;
        q_s0_d[k*IN_W +: IN_W] = CH_EN[k] ? Q_IN[k*IN_W +: IN_W] : '0;
      end
    end
  end

  // Input stage registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_s0_q <= 1'b0;
      mode_s0_q  <= 1'b0;
      i_s0_q     <= '0;
      q_s0_q     <= '0;
    end else begin
      valid_s0_q <= IN_VALID;
      mode_s0_q  <= mode_s0_d;
      i_s0_q     <= i_s0_d;
      q_s0_q     <= q_s0_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree: level l takes N_CH>>l words of IN_W+l bits
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < Lvls; l++) begin : g_lvl
    localparam int unsigned Cnt = N_CH >> l;
    localparam int unsigned LW  = IN_W + l;

    logic [Cnt*LW-1:0]          i_in, q_in;
    logic                       v_in, m_in;
    logic [(Cnt/2)*(LW+1)-1:0]  i_out, q_out;
    logic                       v_out, m_out;

    if (l == 0) begin : g_head
      assign i_in = i_s0_q;
      assign q_in = q_s0_q;
      assign v_in = valid_s0_q;
      assign m_in = mode_s0_q;
    end else begin : g_tail
      assign i_in = g_lvl[l-1].i_out;
      assign q_in = g_lvl[l-1].q_out;
      assign v_in = g_lvl[l-1].v_out;
      assign m_in = g_lvl[l-1].m_out;
    end

    mimo_add_stage #(
      .IN_CNT (Cnt),
      .W      (LW)
    ) u_add (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .valid_i (v_in),
      .mode_i  (m_in),
      .i_i     (i_in),
      .q_i     (q_in),
      .valid_o (v_out),
      .mode_o  (m_out),
      .i_o     (i_out),
      .q_o     (q_out)
    );
  end

  logic signed [FW-1:0] i_sum, q_sum;
  logic                 fin_valid, fin_mode;

  assign i_sum     = g_lvl[Lvls-1].i_out;
  assign q_sum     = g_lvl[Lvls-1].q_out;
  assign fin_valid = g_lvl[Lvls-1].v_out;
  assign fin_mode  = g_lvl[Lvls-1].m_out;

  // ---------------------------------------------------------------------------
  // Output stage: round/shift, saturate, register, sticky flag
  // ---------------------------------------------------------------------------
  logic signed [RW-1:0] i_ext, q_ext;
  logic signed [RW-1:0] i_rnd, q_rnd;
  logic signed [RW-1:0] i_r, q_r;

  // AVG adds half an LSB of the result before the arithmetic shift (round half up).
  // The divisor is always N_CH, independent of how many chains were enabled.
  always_comb begin
    i_ext = RW'(i_sum);
    q_ext = RW'(q_sum);
    i_rnd = (i_ext + Half) >>> Lvls;
    q_rnd = (q_ext + Half) >>> Lvls;
    if (fin_mode == MODE_SUM) begin
      i_r = i_ext;
      q_r = q_ext;
    end else begin
      i_r = i_rnd;
      q_r = q_rnd;
    end
  end

  logic [OUT_W-1:0] i_res, q_res;
  logic             clip_i, clip_q;

  if (SatEn) begin : g_sat
    localparam logic signed [RW-1:0] SatMax = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SatMin = ~SatMax;

    // Clamp each rail to the signed OUT_W range and report which rail clipped.
    always_comb begin
      i_res  = i_r[OUT_W-1:0];
      q_res  = q_r[OUT_W-1:0];
      clip_i = 1'b0;
      clip_q = 1'b0;
      if (i_r > SatMax) begin
        i_res  = SatMax[OUT_W-1:0];
        clip_i = 1'b1;
      end else if (i_r < SatMin) begin
        i_res  = SatMin[OUT_W-1:0];
        clip_i = 1'b1;
      end
      if (q_r > SatMax) begin
        q_res  = SatMax[OUT_W-1:0];
        clip_q = 1'b1;
      end else if (q_r < SatMin) begin
        q_res  = SatMin[OUT_W-1:0];
        clip_q = 1'b1;
      end
    end
  end else begin : g_nosat
    // Output is wide enough for any result; just sign-extend or drop redundant sign bits.
    always_comb begin
      i_res  = OUT_W'(i_r);
      q_res  = OUT_W'(q_r);
      clip_i = 1'b0;
      clip_q = 1'b0;
    end
  end

  logic             out_valid_q;
  logic [OUT_W-1:0] i_total_d, i_total_q;
  logic [OUT_W-1:0] q_total_d, q_total_q;
  logic             sat_flag_d, sat_flag_q;

  // Totals hold between valid samples; a clip on this edge beats a clear request.
  always_comb begin
    i_total_d  = i_total_q;
    q_total_d  = q_total_q;
    sat_flag_d = sat_flag_q;
    if (fin_valid) begin
      i_total_d = i_res;
      q_total_d = q_res;
    end
    if (fin_valid && (clip_i || clip_q)) begin
      sat_flag_d = 1'b1;
    end else if (CLR_FLAG) begin
      sat_flag_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      i_total_q   <= '0;
      q_total_q   <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      out_valid_q <= fin_valid;
      i_total_q   <= i_total_d;
      q_total_q   <= q_total_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign I_TOTAL   = i_total_q;
  assign Q_TOTAL   = q_total_q;
  assign SAT_FLAG  = sat_flag_q;

endmodule
